// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared types and constants for the four-VC weighted round-robin scheduler.
package vc_wrr_scheduler_pkg;

    localparam int NUM_VC   = 4;
    localparam int VC_IDX_W = 2;

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // One entry of the pop-to-push delay line.
    typedef struct packed {
        logic    valid;
        vc_idx_t idx;
    } pop_tag_t;

    function automatic logic [NUM_VC-1:0] vc_onehot(input vc_idx_t idx);
        vc_onehot      = '0;
        vc_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/vc_pop_delay.sv
// READ_LAT-stage shift register aligning each VC pop with the cycle its data is valid.
module vc_pop_delay
    import vc_wrr_scheduler_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic     clk_i,
    input  logic     clr_i,
    input  pop_tag_t tag_i,
    output pop_tag_t tag_o
);

    pop_tag_t stage_q [READ_LAT];

    // NOTE: the stages are cleared on reset because a stale valid bit would fire a spurious push.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            // NOTE: non-blocking updates make each stage take its predecessor's old value.
            for (int i = 1; i < READ_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[READ_LAT-1];

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin drain of four VC FIFOs into the main FIFO, with
// backpressure, skip of empty/disabled VCs and weights latched only while idle.
module vc_wrr_scheduler
    import vc_wrr_scheduler_pkg::*;
#(
    parameter int WEIGHT_W = 8,
    parameter int READ_LAT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [NUM_VC*WEIGHT_W-1:0] table_i,
    input  logic [NUM_VC-1:0]          empty_in_i,
    input  logic                       almost_full_dest_i,
    input  logic                       full_dest_i,
    output logic [NUM_VC-1:0]          pop_o,
    output logic                       push_dest_o,
    output logic [VC_IDX_W-1:0]        sel_dest_o,
    output logic                       busy_o,
    output logic                       overflow_err_o
);

    localparam int                  CNT_W      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);

    state_e              state_q;
    vc_idx_t             ptr_q;
    vc_idx_t             ptr_inc;
    logic [WEIGHT_W-1:0] credit_q;
    logic [WEIGHT_W-1:0] weight_q [NUM_VC];
    logic [CNT_W-1:0]    drain_cnt_q;
    logic                overflow_q;
    logic                stop;
    logic                vc_ready;
    logic                pop_en;
    pop_tag_t            tag_in;
    pop_tag_t            tag_out;

    assign stop     = almost_full_dest_i | full_dest_i;
    assign ptr_inc  = ptr_q + vc_idx_t'(1);
    assign vc_ready = (weight_q[ptr_q] != '0) && !empty_in_i[ptr_q];
    assign pop_en   = (state_q == S_RUN) && enable_i && !stop && vc_ready;
    assign pop_o    = pop_en ? vc_onehot(ptr_q) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            credit_q    <= '0;
            drain_cnt_q <= '0;
            for (int i = 0; i < NUM_VC; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int i = 0; i < NUM_VC; i++) begin
                        weight_q[i] <= table_i[i*WEIGHT_W +: WEIGHT_W];
                    end
                    if (enable_i) begin
                        state_q  <= S_RUN;
                        ptr_q    <= '0;
                        // Shadows load this same cycle, so take VC0's weight straight from the table.
                        credit_q <= table_i[0 +: WEIGHT_W];
                    end
                end
                S_RUN: begin
                    if (!enable_i) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= '0;
                    end else if (!stop) begin
                        // A skipped VC and a VC spending its last credit both hand over to the next one.
                        if (!vc_ready || credit_q == CREDIT_ONE) begin
                            ptr_q    <= ptr_inc;
                            credit_q <= weight_q[ptr_inc];
                        end else begin
                            credit_q <= credit_q - CREDIT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tag_in = '{valid: |pop_o, idx: ptr_q};

    vc_pop_delay #(
        .READ_LAT (READ_LAT)
    ) u_pop_delay (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (tag_out.valid && full_dest_i) begin
            overflow_q <= 1'b1;
        end
    end

    assign push_dest_o    = tag_out.valid;
    assign sel_dest_o     = tag_out.idx;
    assign busy_o         = (state_q != S_IDLE);
    assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Self-checking bench for vc_wrr_scheduler; pushes are tracked by a scoreboard of expected pops.
module tb_vc_wrr_scheduler;

    localparam int WW = 8;
    localparam int RL = 2;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            enable = 1'b0;
    logic [4*WW-1:0] tbl    = '0;
    logic [3:0]      empty  = '0;
    logic            afull  = 1'b0;
    logic            full   = 1'b0;
    logic [3:0]      pop;
    logic            push;
    logic [1:0]      sel;
    logic            busy;
    logic            ovf;

    vc_wrr_scheduler #(
        .WEIGHT_W (WW),
        .READ_LAT (RL)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .enable_i           (enable),
        .table_i            (tbl),
        .empty_in_i         (empty),
        .almost_full_dest_i (afull),
        .full_dest_i        (full),
        .pop_o              (pop),
        .push_dest_o        (push),
        .sel_dest_o         (sel),
        .busy_o             (busy),
        .overflow_err_o     (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic expect_push(input int idx);
        exp_t e;
        e.due = cyc + RL;
        e.idx = 2'(idx);
        exp_q.push_back(e);
    endtask

    // Every monitored cycle: a push exactly when a predicted pop comes due, otherwise none.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            n_cmp++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (push !== 1'b1 || sel !== e.idx) begin
                    n_err++;
                    $display("FAIL push_sb: got push=%b sel=%0d, expected push=1 sel=%0d (cycle %0d)",
                             push, sel, e.idx, cyc);
                end
            end else if (push !== 1'b0) begin
                n_err++;
                $display("FAIL push_idle: got push=%b, expected 0 (cycle %0d)", push, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick();
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (RL + 3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++;
        if ({pop, push, sel, busy, ovf} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, expected 000000000", {pop, push, sel, busy, ovf});
        end
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || pop !== 4'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b pop=%b, expected busy=0 pop=0000", busy, pop);
        end
        tick();
    endtask

    task automatic test_weighted();
        int         seq[5] = '{0, 0, 1, 2, 3};
        logic [3:0] exp;
        tbl   = {8'd1, 8'd1, 8'd1, 8'd2};
        empty = 4'b0000;
        start_run();
        for (int i = 0; i < 15; i++) begin
            exp = 4'b0001 << seq[i % 5];
            @(negedge clk);
            n_cmp++;
            if (pop !== exp || busy !== 1'b1) begin
                n_err++;
                $display("FAIL weighted[%0d]: got pop=%b busy=%b, expected pop=%b busy=1", i, pop, busy, exp);
            end
            expect_push(seq[i % 5]);
            tick();
        end
        go_idle();
    endtask

    task automatic test_skip_empty();
        int         pidx[4] = '{-1, 1, -1, 3};
        logic [3:0] exp;
        tbl   = {8'd1, 8'd1, 8'd1, 8'd1};
        empty = 4'b0101;
        start_run();
        for (int i = 0; i < 12; i++) begin
            exp = (pidx[i % 4] < 0) ? 4'b0000 : 4'b0001 << pidx[i % 4];
            @(negedge clk);
            n_cmp++;
            if (pop !== exp) begin
                n_err++;
                $display("FAIL skip_empty[%0d]: got pop=%b, expected %b", i, pop, exp);
            end
            if (pidx[i % 4] >= 0) expect_push(pidx[i % 4]);
            tick();
        end
        go_idle();
        empty = 4'b0000;
    endtask

    task automatic test_backpressure();
        int         pidx[12] = '{0, 0, -1, -1, -1, -1, -1, 0, 1, 1, 1, 2};
        logic [3:0] exp;
        tbl = {8'd3, 8'd3, 8'd3, 8'd3};
        start_run();
        for (int i = 0; i < 12; i++) begin
            afull = (i >= 2 && i <= 6);
            exp   = (pidx[i] < 0) ? 4'b0000 : 4'b0001 << pidx[i];
            @(negedge clk);
            n_cmp++;
            if (pop !== exp) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got pop=%b, expected %b", i, pop, exp);
            end
            if (pidx[i] >= 0) expect_push(pidx[i]);
            tick();
        end
        afull = 1'b0;
        go_idle();
    endtask

    task automatic test_drain();
        tbl = {8'd1, 8'd1, 8'd1, 8'd1};
        start_run();
        @(negedge clk);
        n_cmp++;
        if (pop !== 4'b0001) begin
            n_err++;
            $display("FAIL drain_pop: got %b, expected 0001", pop);
        end
        expect_push(0);
        tick();
        enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pop !== 4'b0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL drain_stop: got pop=%b busy=%b, expected pop=0000 busy=1", pop, busy);
        end
        tick();
        enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || pop !== 4'b0000 || push !== 1'b1 || sel !== 2'd0) begin
            n_err++;
            $display("FAIL drain_push: got busy=%b pop=%b push=%b sel=%0d, expected 1 0000 1 0",
                     busy, pop, push, sel);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || pop !== 4'b0000) begin
            n_err++;
            $display("FAIL drain_hold: got busy=%b pop=%b, expected busy=1 pop=0000", busy, pop);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || pop !== 4'b0000) begin
            n_err++;
            $display("FAIL drain_idle: got busy=%b pop=%b, expected busy=0 pop=0000", busy, pop);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || pop !== 4'b0001) begin
            n_err++;
            $display("FAIL drain_restart: got busy=%b pop=%b, expected busy=1 pop=0001", busy, pop);
        end
        expect_push(0);
        tick();
        go_idle();
    endtask

    task automatic test_table_latch();
        int         old_seq[5] = '{0, 0, 1, 2, 3};
        int         new_seq[5] = '{0, 1, 1, 2, 3};
        logic [3:0] exp;
        tbl = {8'd1, 8'd1, 8'd1, 8'd2};
        start_run();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) tbl = {8'd1, 8'd1, 8'd2, 8'd1};
            exp = 4'b0001 << old_seq[i % 5];
            @(negedge clk);
            n_cmp++;
            if (pop !== exp) begin
                n_err++;
                $display("FAIL table_hold[%0d]: got pop=%b, expected %b", i, pop, exp);
            end
            expect_push(old_seq[i % 5]);
            tick();
        end
        go_idle();
        start_run();
        for (int i = 0; i < 10; i++) begin
            exp = 4'b0001 << new_seq[i % 5];
            @(negedge clk);
            n_cmp++;
            if (pop !== exp) begin
                n_err++;
                $display("FAIL table_new[%0d]: got pop=%b, expected %b", i, pop, exp);
            end
            expect_push(new_seq[i % 5]);
            tick();
        end
        go_idle();
    endtask

    task automatic test_reset_midrun();
        tbl = {8'd1, 8'd1, 8'd1, 8'd1};
        start_run();
        @(negedge clk);
        n_cmp++;
        if (pop !== 4'b0001) begin
            n_err++;
            $display("FAIL midrun_pop: got %b, expected 0001", pop);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pop, push, sel, busy, ovf} !== 9'b0) begin
            n_err++;
            $display("FAIL midrun_reset: got %b, expected 000000000", {pop, push, sel, busy, ovf});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (pop !== 4'b0001) begin
            n_err++;
            $display("FAIL midrun_ptr0: got pop=%b, expected 0001", pop);
        end
        expect_push(0);
        tick();
        go_idle();
    endtask

    task automatic test_overflow();
        tbl = {8'd1, 8'd1, 8'd1, 8'd1};
        start_run();
        @(negedge clk);
        expect_push(0);
        tick();
        full = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pop !== 4'b0000 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_stop: got pop=%b ovf=%b, expected 0000 0", pop, ovf);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_before: got %b, expected 0", ovf);
        end
        tick();
        full = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b1 || pop !== 4'b0010) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b pop=%b, expected 1 0010", ovf, pop);
        end
        expect_push(1);
        tick();
        go_idle();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b, expected 1", ovf);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b, expected 0", ovf);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_weighted();
        test_skip_empty();
        test_backpressure();
        test_drain();
        test_table_latch();
        test_reset_midrun();
        test_overflow();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_empty: got %0d pending pushes, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
